alu_wb_seq: RTL and testbench
=============================

ALU_WB_SEQ -- requirements
Module: alu_wb_seq

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 16 bits and register addresses at 3 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; SHALL force the reset state immediately, independent of clk.
REQ-004 instr  input  16  instruction word: op=[15:12], wa=[11:9], ra=[8:6], sa=[5:3], imm6=[5:0].
REQ-005 instr_valid  input  1  instr is valid this cycle.
REQ-006 instr_ready  output  1  block accepts instr; SHALL be 1 exactly when state=IDLE.
REQ-007 R_Adr  output  3  register-file R read address.
REQ-008 S_Adr  output  3  register-file S read address.
REQ-009 R  input  16  register-file R read data, combinational from R_Adr.
REQ-010 S  input  16  register-file S read data, combinational from S_Adr.
REQ-011 W_Adr  output  3  register-file write address.
REQ-012 W  output  16  write-back data.
REQ-013 we  output  1  register-file write enable.
REQ-014 flags  output  4  {N,Z,C,V}, registered.
REQ-015 done  output  1  one-cycle pulse marking instruction completion.
REQ-016 illegal  output  1  one-cycle pulse, coincident with done, for a reserved opcode.

Function
REQ-017 Accept: instr SHALL be latched on the clk edge where instr_valid=1 and state=IDLE; instr is ignored in every other state.
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WB; transitions: IDLE->READ on accept; READ->EXEC; EXEC->WB (after 16 EXEC cycles for MUL, 1 otherwise); WB->IDLE.
REQ-019 R_Adr, S_Adr and W_Adr SHALL be driven from the latched ra, sa and wa from READ through WB; they SHALL be 0 in IDLE.
REQ-020 R and S SHALL be captured into internal operand registers at the end of READ; wa equal to ra or sa SHALL therefore be safe.
REQ-021 we SHALL be 1 only in WB, and only for a writing opcode.
REQ-022 In WB, W SHALL hold the result; W SHALL hold its last value in all other states.
REQ-023 done SHALL be 1 only in WB; latency from the accept edge to done SHALL be 3 cycles, or 18 for MUL.
REQ-024 Opcodes: 0 ADD R+S; 1 SUB R-S; 2 AND; 3 OR; 4 XOR; 5 NOT R; 6 SHL R by 1; 7 SHR R by 1 (logical); 8 MUL low 16 bits of R*S, unsigned shift-add, 1 bit per cycle; 9 LDI W={{10{imm6[5]}},imm6}; F NOP, no write.
REQ-025 Opcodes A-E SHALL behave as NOP (we=0, flags unchanged) and SHALL pulse illegal in WB.
REQ-026 Flag N SHALL be result[15] and Z SHALL be (result==0).
REQ-027 Flag C SHALL be: ADD carry-out; SUB borrow (R<S unsigned); SHL R[15]; SHR R[0]; MUL 1 when product[31:16]!=0; 0 for all other ops.
REQ-028 Flag V SHALL be signed overflow for ADD and SUB and 0 for all other ops.
REQ-029 Flags SHALL update on the WB edge only for writing opcodes.
REQ-030 Back-to-back: with instr_valid held high, the next instr SHALL be accepted in the IDLE cycle immediately after WB, giving a 4-cycle throughput for non-MUL ops.

Reset
REQ-031 During reset, state SHALL be IDLE, W=0, W_Adr=R_Adr=S_Adr=0, we=0, flags=0, done=0, illegal=0, the operand and MUL registers SHALL be 0, and instr_ready SHALL be 1.
REQ-032 Reset asserted mid-instruction (including mid-MUL) SHALL abort it with no write and no done pulse; the first instruction after reset deasserts SHALL be accepted normally.

Verification
REQ-033 ADD with R=0x7FFF, S=0x0001 -> WB: we=1, W=0x8000, flags N=1 Z=0 C=0 V=1; done 3 cycles after accept.
REQ-034 SUB with R=0x0003, S=0x0005 to wa=ra -> W=0xFFFE, C=1, V=0; the written register reads 0xFFFE afterwards.
REQ-035 MUL with R=0x0123, S=0x0010 -> W=0x1230, C=0, done exactly 18 cycles after accept; instr_ready stays 0 throughout.
REQ-036 LDI with imm6=0x2A -> W=0xFFEA, N=1; then opcode 0xB -> we=0, illegal=1, done=1, flags unchanged.
REQ-037 Reset asserted on EXEC cycle 8 of a MUL -> outputs take their reset values immediately, no we pulse; next ADD completes correctly.
REQ-038 Two ADDs with instr_valid held high -> second accept occurs exactly 4 cycles after the first, with two WB pulses to the correct W_Adr values.

Source files
------------

// File: rtl/alu_wb_seq.sv
// Multi-cycle 16-bit ALU sequencer: IDLE -> READ -> EXEC -> WB around an external register file.
// MUL runs as an unsigned shift-add, one multiplier bit per EXEC cycle.
module alu_wb_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    input  logic [15:0] R,
    input  logic [15:0] S,
    output logic [2:0]  W_Adr,
    output logic [15:0] W,
    output logic        we,
    output logic [3:0]  flags,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;

    state_t      state_q, state_d;
    logic [15:0] instr_q;
    logic [15:0] op_a_q, op_b_q;
    logic [31:0] mul_acc_q, mul_mcand_q;
    logic [3:0]  mul_cnt_q;
    logic [15:0] w_q;
    logic [3:0]  flags_q;

    logic [3:0]  op;
    logic        is_mul, is_write, is_illegal, accept;
    logic [31:0] mul_sum;
    logic [15:0] res;
    logic        res_c, res_v;

    assign op         = instr_q[15:12];
    assign is_mul     = (op == OP_MUL);
    assign is_write   = (op <= OP_LDI);
    assign is_illegal = (op >= 4'hA) && (op <= 4'hE);
    assign accept     = instr_valid && (state_q == IDLE);
    assign mul_sum    = mul_acc_q + (op_b_q[0] ? mul_mcand_q : 32'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    if (!is_mul || mul_cnt_q == 4'd15) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res   = 16'd0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                {res_c, res} = {1'b0, op_a_q} + {1'b0, op_b_q};
                res_v = (op_a_q[15] == op_b_q[15]) && (res[15] != op_a_q[15]);
            end
            OP_SUB: begin
                res   = op_a_q - op_b_q;
                res_c = (op_a_q < op_b_q);
                res_v = (op_a_q[15] != op_b_q[15]) && (res[15] != op_a_q[15]);
            end
            OP_AND: res = op_a_q & op_b_q;
            OP_OR:  res = op_a_q | op_b_q;
            OP_XOR: res = op_a_q ^ op_b_q;
            OP_NOT: res = ~op_a_q;
            OP_SHL: begin
                res   = {op_a_q[14:0], 1'b0};
                res_c = op_a_q[15];
            end
            OP_SHR: begin
                res   = {1'b0, op_a_q[15:1]};
                res_c = op_a_q[0];
            end
            OP_MUL: begin
                // Final shift-add step folds in here, so the result is ready on the EXEC->WB edge.
                res   = mul_sum[15:0];
                res_c = |mul_sum[31:16];
            end
            OP_LDI: res = {{10{instr_q[5]}}, instr_q[5:0]};
            default: ;
        endcase
    end

    // NOTE: every datapath register, including the operand and multiplier state, is cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q     <= 16'd0;
            op_a_q      <= 16'd0;
            op_b_q      <= 16'd0;
            mul_acc_q   <= 32'd0;
            mul_mcand_q <= 32'd0;
            mul_cnt_q   <= 4'd0;
            w_q         <= 16'd0;
            flags_q     <= 4'd0;
        end else begin
            if (accept) instr_q <= instr;
            if (state_q == READ) begin
                op_a_q      <= R;
                op_b_q      <= S;
                mul_acc_q   <= 32'd0;
                mul_mcand_q <= {16'd0, R};
                mul_cnt_q   <= 4'd0;
            end
            if (state_q == EXEC && is_mul) begin
                mul_acc_q   <= mul_sum;
                mul_mcand_q <= {mul_mcand_q[30:0], 1'b0};
                op_b_q      <= {1'b0, op_b_q[15:1]};
                mul_cnt_q   <= mul_cnt_q + 4'd1;
            end
            if (state_q == EXEC && state_d == WB && is_write) begin
                w_q     <= res;
                flags_q <= {res[15], (res == 16'd0), res_c, res_v};
            end
        end
    end

    always_comb begin
        instr_ready = (state_q == IDLE);
        R_Adr       = 3'd0;
        S_Adr       = 3'd0;
        W_Adr       = 3'd0;
        if (state_q != IDLE) begin
            R_Adr = instr_q[8:6];
            S_Adr = instr_q[5:3];
            W_Adr = instr_q[11:9];
        end
        we      = (state_q == WB) && is_write;
        done    = (state_q == WB);
        illegal = (state_q == WB) && is_illegal;
    end

    assign W     = w_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu_wb_seq.sv
// Directed bench for alu_wb_seq with a behavioural 8x16 register file.
// Expected results are hand-computed from the preloaded register contents.
module tb_alu_wb_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  R_Adr, S_Adr, W_Adr;
    logic [15:0] R, S, W;
    logic        we;
    logic [3:0]  flags;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rf [8] = '{16'h0000, 16'h7FFF, 16'h0001, 16'h0003,
                            16'h0005, 16'h0123, 16'h0010, 16'h0000};

    alu_wb_seq dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .R_Adr       (R_Adr),
        .S_Adr       (S_Adr),
        .R           (R),
        .S           (S),
        .W_Adr       (W_Adr),
        .W           (W),
        .we          (we),
        .flags       (flags),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    assign R = rf[R_Adr];
    assign S = rf[S_Adr];

    always @(posedge clk) begin
        if (we) rf[W_Adr] <= W;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] wa,
                                        input logic [2:0] ra, input logic [2:0] sa);
        return {op, wa, ra, sa, 3'b000};
    endfunction

    task automatic send(input logic [15:0] ins);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Issues one instruction and checks the WB cycle; latency counts clock edges from the accept edge.
    task automatic run(input string tag, input logic [15:0] ins, input int exp_lat,
                       input logic exp_we, input logic [15:0] exp_w,
                       input logic [3:0] exp_flags, input logic exp_ill);
        int   lat;
        logic ready_low;
        lat       = 0;
        ready_low = 1'b1;
        send(ins);
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check({tag, " R_Adr"}, {29'd0, R_Adr}, {29'd0, ins[8:6]});
                check({tag, " S_Adr"}, {29'd0, S_Adr}, {29'd0, ins[5:3]});
            end
            if (!done && instr_ready) ready_low = 1'b0;
        end while (!done && lat < 40);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " ready low"}, {31'd0, ready_low}, 32'd1);
        check({tag, " we"}, {31'd0, we}, {31'd0, exp_we});
        check({tag, " W_Adr"}, {29'd0, W_Adr}, {29'd0, ins[11:9]});
        check({tag, " W"}, {16'd0, W}, {16'd0, exp_w});
        check({tag, " flags"}, {28'd0, flags}, {28'd0, exp_flags});
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        @(negedge clk);
        check({tag, " W held"}, {16'd0, W}, {16'd0, exp_w});
        if (exp_we) check({tag, " rf write"}, {16'd0, rf[ins[11:9]]}, {16'd0, exp_w});
    endtask

    initial begin
        int          acc0, acc1, nwb;
        logic [2:0]  wb_adr [2];
        logic [15:0] wb_dat [2];

        reset       = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        #1;
        check("reset ready", {31'd0, instr_ready}, 32'd1);
        check("reset we", {31'd0, we}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset W", {16'd0, W}, 32'd0);
        check("reset flags", {28'd0, flags}, 32'd0);
        check("reset addr", {23'd0, R_Adr, S_Adr, W_Adr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run("ADD ovf", enc(4'h0, 3'd7, 3'd1, 3'd2), 3, 1'b1, 16'h8000, 4'b1001, 1'b0);
        run("SHL msb", enc(4'h6, 3'd0, 3'd7, 3'd0), 3, 1'b1, 16'h0000, 4'b0110, 1'b0);
        run("SUB wa=ra", enc(4'h1, 3'd3, 3'd3, 3'd4), 3, 1'b1, 16'hFFFE, 4'b1010, 1'b0);
        run("XOR", enc(4'h4, 3'd0, 3'd3, 3'd4), 3, 1'b1, 16'hFFFB, 4'b1000, 1'b0);
        run("MUL", enc(4'h8, 3'd7, 3'd5, 3'd6), 18, 1'b1, 16'h1230, 4'b0000, 1'b0);
        run("LDI", {4'h9, 3'd2, 3'd0, 6'h2A}, 3, 1'b1, 16'hFFEA, 4'b1000, 1'b0);
        run("op B", enc(4'hB, 3'd5, 3'd0, 3'd0), 3, 1'b0, 16'hFFEA, 4'b1000, 1'b1);

        // Abort a MUL on its eighth EXEC cycle.
        send(enc(4'h8, 3'd4, 3'd5, 3'd6));
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort ready", {31'd0, instr_ready}, 32'd1);
        check("abort we", {31'd0, we}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort W", {16'd0, W}, 32'd0);
        check("abort flags", {28'd0, flags}, 32'd0);
        check("abort addr", {23'd0, R_Adr, S_Adr, W_Adr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort no write", {16'd0, rf[4]}, 32'h0005);
        run("ADD post", enc(4'h0, 3'd0, 3'd6, 3'd5), 3, 1'b1, 16'h0133, 4'b0000, 1'b0);

        // Back-to-back ADDs with instr_valid held high.
        acc0 = -1;
        acc1 = -1;
        nwb  = 0;
        @(negedge clk);
        instr       = enc(4'h0, 3'd1, 3'd6, 3'd6);
        instr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (instr_ready && instr_valid) begin
                if (acc0 < 0) acc0 = c;
                else if (acc1 < 0) acc1 = c;
            end
            if (we && nwb < 2) begin
                wb_adr[nwb] = W_Adr;
                wb_dat[nwb] = W;
                nwb++;
            end
            @(negedge clk);
            if (acc0 >= 0 && acc1 < 0) instr = enc(4'h0, 3'd2, 3'd1, 3'd0);
            if (acc1 >= 0) instr_valid = 1'b0;
        end
        check("b2b spacing", acc1 - acc0, 4);
        check("b2b wb count", nwb, 2);
        if (nwb == 2) begin
            check("b2b wadr0", {29'd0, wb_adr[0]}, 32'd1);
            check("b2b w0", {16'd0, wb_dat[0]}, 32'h0020);
            check("b2b wadr1", {29'd0, wb_adr[1]}, 32'd2);
            check("b2b w1", {16'd0, wb_dat[1]}, 32'h0153);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
